// File: rtl/axi_write_data_arbiter_pkg.sv
// Shared interconnect definitions for the AXI write-data arbiter.
package axi_write_data_arbiter_pkg;

    localparam int unsigned LEN_W_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } wda_state_e;

    // Pick the AWLEN of the granted master (0 = M0, 1 = M1).
    function automatic logic [LEN_W_DEF-1:0] pick_len(input logic sel,
                                                      input logic [LEN_W_DEF-1:0] len0,
                                                      input logic [LEN_W_DEF-1:0] len1);
        return sel ? len1 : len0;
    endfunction

endpackage

// File: rtl/axi_write_data_arbiter_if.sv
// Bundle of the two-master AW/W handshake signals plus arbiter status outputs.
interface axi_write_data_arbiter_if
    import axi_write_data_arbiter_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
);

    logic             M0_AWVALID, M1_AWVALID;
    logic [LEN_W-1:0] M0_AWLEN, M1_AWLEN;
    logic             M0_AWREADY, M1_AWREADY;
    logic             M0_WVALID, M1_WVALID, M0_WLAST, M1_WLAST;
    logic             M0_WREADY, M1_WREADY;
    logic             S_WREADY, S_WVALID, S_WLAST;
    logic             Sel, Busy, Last_Mismatch;

    // Environment side: masters and slave drive requests and ready.
    modport master (
        output M0_AWVALID, M1_AWVALID, M0_AWLEN, M1_AWLEN,
        output M0_WVALID, M1_WVALID, M0_WLAST, M1_WLAST, S_WREADY,
        input  M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY,
        input  S_WVALID, S_WLAST, Sel, Busy, Last_Mismatch
    );

    // Arbiter side.
    modport slave (
        input  M0_AWVALID, M1_AWVALID, M0_AWLEN, M1_AWLEN,
        input  M0_WVALID, M1_WVALID, M0_WLAST, M1_WLAST, S_WREADY,
        output M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY,
        output S_WVALID, S_WLAST, Sel, Busy, Last_Mismatch
    );

endinterface

// File: rtl/axi_write_data_arbiter_rr_arbiter_2.sv
// Two-way priority pick: lone requester wins, ties go to the master named by prio.
module rr_arbiter_2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic prio_i,
    output logic grant_c_o,
    output logic valid_c_o
);

    assign valid_c_o = req0_i | req1_i;
    assign grant_c_o = (req0_i & req1_i) ? prio_i : req1_i;

endmodule

// File: rtl/axi_write_data_arbiter.sv
// Routes one master's W burst at a time to the slave, granted per AW handshake,
// with arbiter-generated WLAST and a pulse when the master's WLAST disagrees.
module axi_write_data_arbiter
    import axi_write_data_arbiter_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    axi_write_data_arbiter_if.slave  bus
);

    wda_state_e       state_q, state_d;
    logic             sel_q, sel_d;
    logic             prio_q, prio_d;
    logic             busy_q, busy_d;
    logic             mism_q, mism_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic grant_c, req_valid_c;
    logic is_idle, is_data, at_last, aw_hs, w_hs, wvalid_sel, wlast_sel;

    rr_arbiter_2 u_rr (
        .req0_i    (bus.M0_AWVALID),
        .req1_i    (bus.M1_AWVALID),
        .prio_i    (prio_q),
        .grant_c_o (grant_c),
        .valid_c_o (req_valid_c)
    );

    assign is_idle    = (state_q == ST_IDLE);
    assign is_data    = (state_q == ST_DATA);
    assign at_last    = (beat_q == len_q);
    assign aw_hs      = is_idle & req_valid_c;
    assign wvalid_sel = sel_q ? bus.M1_WVALID : bus.M0_WVALID;
    assign wlast_sel  = sel_q ? bus.M1_WLAST  : bus.M0_WLAST;
    assign w_hs       = bus.S_WVALID & bus.S_WREADY;

    // Address accept and W-channel steering toward the selected master.
    assign bus.M0_AWREADY = aw_hs & ~grant_c;
    assign bus.M1_AWREADY = aw_hs & grant_c;
    assign bus.S_WVALID   = is_data & wvalid_sel;
    assign bus.S_WLAST    = is_data & at_last;
    assign bus.M0_WREADY  = is_data & ~sel_q & bus.S_WREADY;
    assign bus.M1_WREADY  = is_data & sel_q & bus.S_WREADY;

    assign bus.Sel           = sel_q;
    assign bus.Busy          = busy_q;
    assign bus.Last_Mismatch = mism_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            busy_q  <= 1'b0;
            mism_q  <= 1'b0;
            beat_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            busy_q  <= busy_d;
            mism_q  <= mism_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        prio_d  = prio_q;
        busy_d  = busy_q;
        beat_d  = beat_q;
        len_d   = len_q;
        // Master's WLAST is only advisory; a disagreement is flagged, never acted on.
        mism_d  = w_hs & (wlast_sel != at_last);

        case (state_q)
            ST_IDLE: begin
                if (aw_hs) begin
                    state_d = ST_DATA;
                    sel_d   = grant_c;
                    len_d   = LEN_W'(pick_len(grant_c, LEN_W_DEF'(bus.M0_AWLEN),
                                              LEN_W_DEF'(bus.M1_AWLEN)));
                    beat_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    if (at_last) begin
                        state_d = ST_IDLE;
                        beat_d  = '0;
                        busy_d  = 1'b0;
                        prio_d  = ~sel_q;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
